count_wrap_monitor: RTL and testbench
=====================================

// Module: count_wrap_monitor
// PURPOSE
//  Downstream observer of the 4-bit up/down counter. Samples count/dir every clock.
//  Detects wrap-around, direction changes and (optionally) illegal steps.
//  Queues one timestamped event record per cycle into a small FIFO drained over a valid/ready port.
//  Maintains a saturating wrap tally for status readout.
// PARAMETERS
//  CNT_W       4   width of observed count (must match counter)
//  STAMP_W     8   width of free-running cycle timestamp
//  FIFO_DEPTH  4   event FIFO entries; power of 2, >=2
//  WRAPC_W     8   width of saturating wrap tally
// PORTS
//  clk          in   1            system clock, all logic on rising edge
//  rst_n        in   1            synchronous active-low reset
//  dir          in   1            counter direction: 1=up, 0=down (same net as counter input)
//  count        in   CNT_W        counter output
//  evt_valid    out  1            FIFO head holds an event
//  evt_ready    in   1            consumer accepts head this cycle
//  evt_flags    out  4            {err,dir_chg,dn_wrap,up_wrap} of head entry
//  evt_stamp    out  STAMP_W      timestamp of head entry
//  wrap_cnt     out  WRAPC_W      saturating count of up+down wraps
//  ovf          out  1            sticky: event dropped because FIFO full
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): FSM->PRIME; FIFO empty; stamp=0; wrap_cnt=0; ovf=0.
//    Outputs: evt_valid=0, evt_flags=0, evt_stamp=0. Reset takes priority mid-operation.
//    Queued events are discarded.
//  - FSM PRIME: first edge with rst_n=1 captures prev_count<=count, prev_dir<=dir.
//    No detection on that edge. Next state RUN.
//  - FSM RUN, every edge:
//    - prev_* <= current inputs; stamp <= stamp+1 (mod 2^STAMP_W).
//  - Detection in RUN (combinational on current inputs vs prev_*; MAX=2^CNT_W-1):
//    - up_wrap  = prev_dir==1 && prev_count==MAX && count==0
//    - dn_wrap  = prev_dir==0 && prev_count==0   && count==MAX
//    - dir_chg  = dir != prev_dir
//    - err: see CONFIGURATION
//  - Pushing events:
//    - If any flag is set, one entry {flags,stamp} is pushed at that edge.
//    - Latency: evt_valid rises 1 cycle after the offending count/dir is presented.
//    - Simultaneous flags share one entry. At most one push per cycle.
//  - Handshake:
//    - Pop on edge when evt_valid && evt_ready.
//    - evt_flags/evt_stamp are stable while evt_valid=1 and evt_ready=0.
//    - When empty, evt_flags=0 and evt_stamp=0.
//  - Full FIFO:
//    - Push+pop same edge: both occur, occupancy unchanged.
//    - Push without pop: entry dropped, ovf<=1 (cleared only by reset).
//    - Empty + push: entry visible next cycle; no bypass.
//  - wrap_cnt: increments by 1 on each edge where up_wrap|dn_wrap.
//    Holds at 2^WRAPC_W-1. Counts even when the event is dropped.
//  - Count stall (count==prev_count) is legal and raises no flag.
// CONFIGURATION
//  - Macro COUNT_WRAP_MONITOR_STEP_CHK_EN defined:
//    - err=1 when, in RUN, count is not prev_count, prev_count+1, or prev_count-1 (mod 2^CNT_W).
//    - flags bit3 is driven by err.
//  - Macro undefined:
//    - no step-check logic; flags bit3 tied 0.
//    - No other behaviour changes.
// TESTING
//  1. Reset held 3 cycles with count toggling randomly.
//     -> evt_valid=0, wrap_cnt=0, ovf=0, stamp=0 throughout.
//  2. dir=1, count steps 13,14,15,0 (evt_ready=1).
//     -> one entry, flags=4'b0001, stamp=stamp at 15->0 edge; wrap_cnt=1.
//  3. dir=0, count 1,0,15. Then dir 0->1 on the cycle count=15.
//     -> entry flags=4'b0010 followed by entry flags=4'b0100.
//     -> Alternative: if both fall on the same edge, a single entry flags=4'b0110.
//  4. evt_ready=0, generate 5 wraps with FIFO_DEPTH=4.
//     -> 4 entries held, ovf=1, wrap_cnt=5.
//     -> Release ready: 4 pops in order of stamp, then evt_valid=0.
//  5. FIFO full, evt_ready=1, wrap on the same edge.
//     -> occupancy stays 4, ovf unchanged, new entry at tail.
//  6. STEP_CHK_EN defined, count jumps 3->7 (dir=1).
//     -> flags=4'b1000.
//     -> Same stimulus without the macro: no entry produced.

Source files
------------

// File: rtl/count_wrap_monitor_if.sv
// Event port of count_wrap_monitor: one event record offered per transfer.
// The producer holds valid and the payload stable until ready is seen high at a rising edge.
interface count_wrap_monitor_if #(
   parameter int STAMP_W = 8
);
   logic               evt_valid;
   logic               evt_ready;
   logic [3:0]         evt_flags;
   logic [STAMP_W-1:0] evt_stamp;

   modport master (
      output evt_valid,
      output evt_flags,
      output evt_stamp,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_flags,
      input  evt_stamp,
      output evt_ready
   );
endinterface

// File: rtl/count_wrap_monitor.sv
// Observer for a 4-bit up/down counter: flags wraps and direction changes, then queues timestamped events.
// Optional step checking is enabled by defining COUNT_WRAP_MONITOR_STEP_CHK_EN.
module count_wrap_monitor #(
   parameter int CNT_W      = 4,
   parameter int STAMP_W    = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int WRAPC_W    = 8,
   localparam int PTR_W     = $clog2(FIFO_DEPTH),
   localparam int LVL_W     = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dir,
   input  logic [CNT_W-1:0]      count,
   count_wrap_monitor_if.master  evt,
   output logic [WRAPC_W-1:0]    wrap_cnt,
   output logic                  ovf,
   output logic                  dbg_state,
   output logic [STAMP_W-1:0]    dbg_stamp,
   output logic [LVL_W-1:0]      dbg_level
);

   typedef enum logic {
      S_PRIME = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
   localparam logic [WRAPC_W-1:0] WRAP_MAX = '1;
   localparam logic [LVL_W-1:0]   LVL_FULL = LVL_W'(FIFO_DEPTH);

   state_t             state;
   state_t             state_nxt;
   logic               run;

   logic [CNT_W-1:0]   prev_count;
   logic               prev_dir;
   logic [STAMP_W-1:0] stamp;

   logic               up_wrap;
   logic               dn_wrap;
   logic               dir_chg;
   logic               err;
   logic [3:0]         flags;

   logic [3:0]         flag_mem  [FIFO_DEPTH];
   logic [STAMP_W-1:0] stamp_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LVL_W-1:0]   level;

   logic               empty;
   logic               full;
   logic               push;
   logic               pop;
   logic               do_push;
   logic               drop;

   // ---------------------------------------------------------------
   // FSM: PRIME only captures the first sample, RUN does detection.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_PRIME;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      run       = 1'b0;
      case (state)
         S_PRIME: begin
            state_nxt = S_RUN;
         end
         S_RUN: begin
            run = 1'b1;
         end
         default: begin
            state_nxt = S_PRIME;
         end
      endcase
   end

   assign dbg_state = state;

   // ---------------------------------------------------------------
   // Previous sample and free-running timestamp.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_count <= '0;
         prev_dir   <= 1'b0;
         stamp      <= '0;
      end else begin
         prev_count <= count;
         prev_dir   <= dir;
         if (run) begin
            stamp <= stamp + STAMP_W'(1);
         end
      end
   end

   assign dbg_stamp = stamp;

   // ---------------------------------------------------------------
   // Detection against the previous sample.
   // ---------------------------------------------------------------
   always_comb begin
      up_wrap = run && prev_dir  && (prev_count == CNT_MAX) && (count == '0);
      dn_wrap = run && !prev_dir && (prev_count == '0)      && (count == CNT_MAX);
      dir_chg = run && (dir != prev_dir);
   end

`ifdef COUNT_WRAP_MONITOR_STEP_CHK_EN
   // A stall or a single step either way is legal; anything else is a skip.
   always_comb begin
      err = run
            && (count != prev_count)
            && (count != prev_count + CNT_W'(1))
            && (count != prev_count - CNT_W'(1));
   end
`else
   assign err = 1'b0;
`endif

   assign flags = {err, dir_chg, dn_wrap, up_wrap};

   // ---------------------------------------------------------------
   // Event FIFO. A full FIFO still accepts a push when the head pops
   // on the same edge; otherwise the new event is lost and ovf sticks.
   // ---------------------------------------------------------------
   always_comb begin
      empty   = (level == '0);
      full    = (level == LVL_FULL);
      push    = |flags;
      pop     = !empty && evt.evt_ready;
      do_push = push && (!full || pop);
      drop    = push && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         flag_mem[wr_ptr]  <= flags;
         stamp_mem[wr_ptr] <= stamp;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         if (drop) begin
            ovf <= 1'b1;
         end
      end
   end

   assign dbg_level = level;

   always_comb begin
      evt.evt_valid = !empty;
      evt.evt_flags = '0;
      evt.evt_stamp = '0;
      if (!empty) begin
         evt.evt_flags = flag_mem[rd_ptr];
         evt.evt_stamp = stamp_mem[rd_ptr];
      end
   end

   // ---------------------------------------------------------------
   // Saturating wrap tally, independent of whether the event was queued.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrap_cnt <= '0;
      end else if ((up_wrap || dn_wrap) && (wrap_cnt != WRAP_MAX)) begin
         wrap_cnt <= wrap_cnt + WRAPC_W'(1);
      end
   end

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor: wraps, direction changes, FIFO full/drop, reset and saturation.
module tb_count_wrap_monitor;

   logic       clk;
   logic       rst_n;
   logic       dir;
   logic [3:0] count;
   logic [7:0] wrap_cnt;
   logic       ovf;
   logic       dbg_state;
   logic [7:0] dbg_stamp;
   logic [2:0] dbg_level;

   int passed = 0;
   int total  = 0;

   count_wrap_monitor_if #(.STAMP_W(8)) evt_if ();

   count_wrap_monitor #(
      .CNT_W      (4),
      .STAMP_W    (8),
      .FIFO_DEPTH (4),
      .WRAPC_W    (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dir       (dir),
      .count     (count),
      .evt       (evt_if.master),
      .wrap_cnt  (wrap_cnt),
      .ovf       (ovf),
      .dbg_state (dbg_state),
      .dbg_stamp (dbg_stamp),
      .dbg_level (dbg_level)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- driver / checker tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_head(input string tag, input logic [3:0] exp_flags, input logic [7:0] exp_stamp);
      check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd1);
      check({tag, "_flags"}, 32'(evt_if.evt_flags), 32'(exp_flags));
      check({tag, "_stamp"}, 32'(evt_if.evt_stamp), 32'(exp_stamp));
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd0);
      check({tag, "_flags"}, 32'(evt_if.evt_flags), 32'd0);
      check({tag, "_stamp"}, 32'(evt_if.evt_stamp), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n            = 1'b0;
      dir              = 1'b0;
      count            = 4'd0;
      evt_if.evt_ready = 1'b0;

      // Reset held with random count activity.
      for (int i = 0; i < 3; i++) begin
         count = 4'($urandom_range(0, 15));
         dir   = 1'($urandom_range(0, 1));
         step();
         check_empty("rst");
         check("rst_wrap", 32'(wrap_cnt), 32'd0);
         check("rst_ovf", 32'(ovf), 32'd0);
         check("rst_stamp", 32'(dbg_stamp), 32'd0);
         check("rst_state", 32'(dbg_state), 32'd0);
      end

      // Prime edge: capture only.
      rst_n = 1'b1;
      dir   = 1'b1;
      count = 4'd12;
      step();
      check("prime_state", 32'(dbg_state), 32'd1);
      check("prime_stamp", 32'(dbg_stamp), 32'd0);
      check("prime_valid", 32'(evt_if.evt_valid), 32'd0);

      // Up wrap 15 -> 0 on the edge with stamp 3.
      evt_if.evt_ready = 1'b1;
      count = 4'd13; step();
      count = 4'd14; step();
      count = 4'd15; step();
      check("up_pre_valid", 32'(evt_if.evt_valid), 32'd0);
      count = 4'd0;  step();
      check_head("up_wrap", 4'b0001, 8'd3);
      check("up_wrap_cnt", 32'(wrap_cnt), 32'd1);
      step();
      check_empty("up_pop");

      // Direction change on a stall, then down wrap 0 -> 15.
      dir = 1'b0; count = 4'd0; step();
      check_head("dchg1", 4'b0100, 8'd5);
      count = 4'd1; step();
      check_empty("dchg1_pop");
      count = 4'd0; step();
      count = 4'd15; step();
      check_head("dn_wrap", 4'b0010, 8'd8);
      check("dn_wrap_cnt", 32'(wrap_cnt), 32'd2);
      dir = 1'b1; step();
      check_head("dchg2", 4'b0100, 8'd9);
      step();
      check_empty("dchg2_pop");

      // Wrap and direction change on the same edge share one entry.
      dir = 1'b0; count = 4'd0; step();
      check_head("shared", 4'b0101, 8'd11);
      check("shared_wrap_cnt", 32'(wrap_cnt), 32'd3);
      step();
      check_empty("shared_pop");

      // Fill with ready low: four down wraps stored, fifth dropped.
      evt_if.evt_ready = 1'b0;
      count = 4'd15; step();
      count = 4'd0;  step();
      count = 4'd15; step();
      count = 4'd0;  step();
      count = 4'd15; step();
      count = 4'd0;  step();
      count = 4'd15; step();
      check("fill_level", 32'(dbg_level), 32'd4);
      check("fill_ovf", 32'(ovf), 32'd0);
      count = 4'd0;  step();
      count = 4'd15; step();
      check("drop_level", 32'(dbg_level), 32'd4);
      check("drop_ovf", 32'(ovf), 32'd1);
      check("drop_wrap_cnt", 32'(wrap_cnt), 32'd8);
      check_head("drop_head", 4'b0010, 8'd13);

      // Full with ready high and a wrap on the same edge.
      count = 4'd0; step();
      check_head("hold_head", 4'b0010, 8'd13);
      count = 4'd15; evt_if.evt_ready = 1'b1; step();
      check("pp_level", 32'(dbg_level), 32'd4);
      check("pp_ovf", 32'(ovf), 32'd1);
      check("pp_wrap_cnt", 32'(wrap_cnt), 32'd9);
      check_head("pp_head", 4'b0010, 8'd15);

      // Drain in stamp order.
      step();
      check_head("drain1", 4'b0010, 8'd17);
      step();
      check_head("drain2", 4'b0010, 8'd19);
      step();
      check_head("drain3", 4'b0010, 8'd23);
      check("drain3_level", 32'(dbg_level), 32'd1);
      step();
      check_empty("drained");
      check("drained_ovf", 32'(ovf), 32'd1);

      // Queue one entry, then reset mid-operation discards it.
      evt_if.evt_ready = 1'b0;
      dir = 1'b1; count = 4'd15; step();
      check_head("pre_rst", 4'b0100, 8'd28);
      rst_n = 1'b0; count = 4'd3; step();
      check_empty("mid_rst");
      check("mid_rst_level", 32'(dbg_level), 32'd0);
      check("mid_rst_ovf", 32'(ovf), 32'd0);
      check("mid_rst_wrap", 32'(wrap_cnt), 32'd0);
      check("mid_rst_stamp", 32'(dbg_stamp), 32'd0);
      check("mid_rst_state", 32'(dbg_state), 32'd0);
      rst_n = 1'b1; step();
      check("reprime_state", 32'(dbg_state), 32'd1);

      // Illegal step 3 -> 7, then a legal down step 7 -> 6.
      count = 4'd7; step();
`ifdef COUNT_WRAP_MONITOR_STEP_CHK_EN
      check_head("skip", 4'b1000, 8'd0);
      count = 4'd6; step();
      check("legal_dn_level", 32'(dbg_level), 32'd1);
`else
      check_empty("skip");
      count = 4'd6; step();
      check("legal_dn_level", 32'(dbg_level), 32'd0);
`endif

      // Wrap tally saturation.
      evt_if.evt_ready = 1'b1;
      dir = 1'b0; count = 4'd0; step();
      for (int i = 0; i < 300; i++) begin
         count = 4'd15; step();
         count = 4'd0;  step();
         if (i == 99) begin
            check("wrap_cnt_100", 32'(wrap_cnt), 32'd100);
         end
      end
      check("wrap_cnt_sat", 32'(wrap_cnt), 32'd255);
      check("sat_ovf", 32'(ovf), 32'd0);
      check_empty("sat_end");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
